// File: rtl/prg_controller.sv
// prg_controller: serial code-RAM programming sequencer with pin synchronisers and core hold-off.
// Define PRG_VERIFY_EN to add a read-back verify step after every RAM write.
module prg_controller #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              prg,
    input  logic              prg_din,
    input  logic              prg_shift_clk,
    input  logic              prg_latch,
    output logic              core_run,
    output logic              core_nreset,
    output logic              ram_write,
    output logic              ram_read,
    output logic              ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
);
    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int BCNT_W  = $clog2(FRAME_W + 1);
    localparam int CNT_W   = $clog2(RELEASE_CYCLES + 1);
    localparam int SYNC_W  = SYNC_STAGES * 4;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef PRG_VERIFY_EN
        ST_VERIFY  = 3'd3,
`endif
        ST_RELEASE = 3'd4
    } state_t;

    logic [SYNC_W-1:0]  sync_r;
    logic               shift_prev_r, latch_prev_r;
    logic               prg_s, din_s, shift_sync_s, latch_sync_s, shift_edge_s, latch_edge_s;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [FRAME_W-1:0] sr_r, sr_s;
    logic [BCNT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic               core_run_r, core_run_s, core_nreset_r, core_nreset_s;
    logic               ram_write_r, ram_write_s, ram_read_r, ram_read_s, ram_sel_r, ram_sel_s;
    logic [ADDR_W-1:0]  ram_addr_r, ram_addr_s;
    logic [DATA_W-1:0]  ram_wdata_r, ram_wdata_s, checksum_r, checksum_s;
    logic               busy_r, busy_s, err_r, err_s;
    logic [ADDR_W:0]    word_count_r, word_count_s;

    assign {prg_s, din_s, shift_sync_s, latch_sync_s} = sync_r[SYNC_W-1 -: 4];
    assign shift_edge_s = shift_sync_s & ~shift_prev_r;
    assign latch_edge_s = latch_sync_s & ~latch_prev_r;

    // Pin synchroniser chain plus previous-sample flops for rising-edge detection
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_r       <= {SYNC_W{1'b0}};
            shift_prev_r <= 1'b0;
            latch_prev_r <= 1'b0;
        end else begin
            sync_r       <= {sync_r[SYNC_W-5:0], prg, prg_din, prg_shift_clk, prg_latch};
            shift_prev_r <= shift_sync_s;
            latch_prev_r <= latch_sync_s;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r       <= ST_RELEASE;
            cnt_r         <= CNT_W'(RELEASE_CYCLES);
            sr_r          <= {FRAME_W{1'b0}};
            bit_cnt_r     <= {BCNT_W{1'b0}};
            core_run_r    <= 1'b0;
            core_nreset_r <= 1'b0;
            ram_write_r   <= 1'b0;
            ram_read_r    <= 1'b0;
            ram_sel_r     <= 1'b0;
            ram_addr_r    <= {ADDR_W{1'b0}};
            ram_wdata_r   <= {DATA_W{1'b0}};
            busy_r        <= 1'b0;
            err_r         <= 1'b0;
            word_count_r  <= {(ADDR_W+1){1'b0}};
            checksum_r    <= {DATA_W{1'b0}};
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            sr_r          <= sr_s;
            bit_cnt_r     <= bit_cnt_s;
            core_run_r    <= core_run_s;
            core_nreset_r <= core_nreset_s;
            ram_write_r   <= ram_write_s;
            ram_read_r    <= ram_read_s;
            ram_sel_r     <= ram_sel_s;
            ram_addr_r    <= ram_addr_s;
            ram_wdata_r   <= ram_wdata_s;
            busy_r        <= busy_s;
            err_r         <= err_s;
            word_count_r  <= word_count_s;
            checksum_r    <= checksum_s;
        end
    end

    // Next-state and next-output logic; strobes default low, everything else holds
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        sr_s          = sr_r;
        bit_cnt_s     = bit_cnt_r;
        core_run_s    = core_run_r;
        core_nreset_s = core_nreset_r;
        ram_write_s   = 1'b0;
        ram_read_s    = 1'b0;
        ram_sel_s     = ram_sel_r;
        ram_addr_s    = ram_addr_r;
        ram_wdata_s   = ram_wdata_r;
        busy_s        = busy_r;
        err_s         = err_r;
        word_count_s  = word_count_r;
        checksum_s    = checksum_r;
        case (state_r)
            ST_RUN: begin
                if (prg_s) begin
                    state_s       = ST_LOAD;
                    core_run_s    = 1'b0;
                    core_nreset_s = 1'b0;
                    busy_s        = 1'b1;
                    ram_sel_s     = 1'b1;
                    err_s         = 1'b0;
                    word_count_s  = {(ADDR_W+1){1'b0}};
                    checksum_s    = {DATA_W{1'b0}};
                    sr_s          = {FRAME_W{1'b0}};
                    bit_cnt_s     = {BCNT_W{1'b0}};
                end else begin
                    core_run_s    = 1'b1;
                    core_nreset_s = 1'b1;
                    ram_sel_s     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!prg_s) begin
                    state_s   = ST_RELEASE;
                    cnt_s     = CNT_W'(RELEASE_CYCLES);
                    ram_sel_s = 1'b0;
                    busy_s    = 1'b0;
                    err_s     = err_r | (bit_cnt_r != {BCNT_W{1'b0}});
                end else if (latch_edge_s) begin
                    // A coincident shift bit is dropped and the latch judged on the old count
                    if (bit_cnt_r == BCNT_W'(FRAME_W)) begin
                        state_s      = ST_WRITE;
                        ram_write_s  = 1'b1;
                        ram_addr_s   = sr_r[FRAME_W-1 -: ADDR_W];
                        ram_wdata_s  = sr_r[DATA_W-1:0];
                        word_count_s = word_count_r + {{ADDR_W{1'b0}}, 1'b1};
                        checksum_s   = checksum_r + sr_r[DATA_W-1:0];
                        bit_cnt_s    = {BCNT_W{1'b0}};
                        err_s        = err_r | shift_edge_s;
                    end else begin
                        err_s     = 1'b1;
                        sr_s      = {FRAME_W{1'b0}};
                        bit_cnt_s = {BCNT_W{1'b0}};
                    end
                end else if (shift_edge_s) begin
                    sr_s      = {sr_r[FRAME_W-2:0], din_s};
                    bit_cnt_s = (bit_cnt_r == BCNT_W'(FRAME_W)) ? bit_cnt_r
                                                                 : bit_cnt_r + {{(BCNT_W-1){1'b0}}, 1'b1};
                end else begin
                    sr_s = sr_r;
                end
            end
            ST_WRITE: begin
                err_s = err_r | shift_edge_s | latch_edge_s;
`ifdef PRG_VERIFY_EN
                state_s    = ST_VERIFY;
                ram_read_s = 1'b1;
                cnt_s      = {CNT_W{1'b0}};
`else
                state_s   = prg_s ? ST_LOAD : ST_RELEASE;
                ram_sel_s = prg_s;
                busy_s    = prg_s;
                cnt_s     = CNT_W'(RELEASE_CYCLES);
`endif
            end
`ifdef PRG_VERIFY_EN
            ST_VERIFY: begin
                // cnt_r marks the verify phase: 0 = read issued, 1 = read data valid
                if (cnt_r == {CNT_W{1'b0}}) begin
                    err_s = err_r | shift_edge_s | latch_edge_s;
                    cnt_s = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    err_s     = err_r | shift_edge_s | latch_edge_s | (ram_rdata != ram_wdata_r);
                    state_s   = prg_s ? ST_LOAD : ST_RELEASE;
                    ram_sel_s = prg_s;
                    busy_s    = prg_s;
                    cnt_s     = CNT_W'(RELEASE_CYCLES);
                end
            end
`endif
            ST_RELEASE: begin
                if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_s       = ST_RUN;
                    core_run_s    = 1'b1;
                    core_nreset_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s       = ST_RELEASE;
                cnt_s         = CNT_W'(RELEASE_CYCLES);
                core_run_s    = 1'b0;
                core_nreset_s = 1'b0;
                ram_sel_s     = 1'b0;
                busy_s        = 1'b0;
                err_s         = 1'b1;
            end
        endcase
    end

`ifndef PRG_VERIFY_EN
    logic unused_rdata_s;
    assign unused_rdata_s = ^ram_rdata;
`endif

    assign core_run    = core_run_r;
    assign core_nreset = core_nreset_r;
    assign ram_write   = ram_write_r;
    assign ram_read    = ram_read_r;
    assign ram_sel     = ram_sel_r;
    assign ram_addr    = ram_addr_r;
    assign ram_wdata   = ram_wdata_r;
    assign busy        = busy_r;
    assign err         = err_r;
    assign word_count  = word_count_r;
    assign checksum    = checksum_r;
endmodule

// File: tb/tb_prg_controller.sv
// Self-checking bench for prg_controller: pin-level serial stimulus, RAM model, frame scoreboard.
`timescale 1ns/1ps
module tb_prg_controller;
    localparam int RELEASE_CYCLES = 4;

    logic       clk = 1'b0;
    logic       nreset, prg, prg_din, prg_shift_clk, prg_latch;
    logic       core_run, core_nreset, ram_write, ram_read, ram_sel, busy, err;
    logic [7:0] ram_addr, ram_wdata, checksum;
    logic [7:0] ram_rdata = 8'h00;
    logic [8:0] word_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic       exp_err;
    logic [8:0] exp_wc;
    logic [7:0] exp_cs;
    int         rd_cnt = 0, rd_late = 0, wr_long = 0;
    logic       prev_wr = 1'b0, run_seen = 1'b0, corrupt = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] mem [256];

    prg_controller dut (
        .clk(clk), .nreset(nreset), .prg(prg), .prg_din(prg_din),
        .prg_shift_clk(prg_shift_clk), .prg_latch(prg_latch),
        .core_run(core_run), .core_nreset(core_nreset), .ram_write(ram_write),
        .ram_read(ram_read), .ram_sel(ram_sel), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .err(err),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Code RAM model: registered read data one cycle after the read strobe
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read) ram_rdata <= corrupt ? 8'h00 : mem[ram_addr];
    end

    // Bus monitor
    always @(negedge clk) begin
        if (nreset) begin
            if (ram_write) begin
                got_q.push_back({ram_addr, ram_wdata});
                if (prev_wr) wr_long++;
            end
            if (ram_read) begin
                rd_cnt++;
                rd_addr = ram_addr;
                if (!prev_wr) rd_late++;
            end
            if (core_run) run_seen = 1'b1;
        end
        prev_wr = ram_write;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        prg_din = b; tick(2);
        prg_shift_clk = 1'b1; tick(3);
        prg_shift_clk = 1'b0; tick(3);
    endtask

    // Sends v[n-1]..v[0] MSB first and latches; collide puts the last shift on the latch edge.
    task automatic send_bits(input logic [31:0] v, input int n, input logic collide);
        logic [31:0] ev;
        int          en;
        for (int i = n - 1; i >= 1; i--) shift_bit(v[i]);
        if (collide) begin
            prg_din = v[0]; tick(2);
            prg_shift_clk = 1'b1; prg_latch = 1'b1; tick(4);
            prg_shift_clk = 1'b0; prg_latch = 1'b0; tick(6);
        end else begin
            shift_bit(v[0]);
            prg_latch = 1'b1; tick(4);
            prg_latch = 1'b0; tick(6);
        end
        ev = collide ? (v >> 1) : v;
        en = collide ? n - 1 : n;
        if (en >= 16) begin
            exp_q.push_back(ev[15:0]);
            exp_wc = exp_wc + 9'd1;
            exp_cs = exp_cs + ev[7:0];
        end else begin
            exp_err = 1'b1;
        end
        if (collide) exp_err = 1'b1;
    endtask

    task automatic start_session(input string name);
        int n = 0;
        got_q.delete(); exp_q.delete();
        exp_err = 1'b0; exp_wc = 9'd0; exp_cs = 8'd0;
        prg = 1'b1;
        while (!busy && n < 40) begin tick(1); n++; end
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL %s_enter_load: busy=%b expected 1 within 40 cycles", name, busy); end
        n_checks++;
        if ({core_run, core_nreset, ram_sel, err, word_count} !== {3'b001, 1'b0, 9'd0})
            begin n_errors++; $display("FAIL %s_load_outputs: run/nrst/sel/err/wc=%b%b%b%b/%0d expected 0010/0", name, core_run, core_nreset, ram_sel, err, word_count); end
    endtask

    task automatic end_session(input string name);
        int n = 0;
        prg = 1'b0;
        while (busy && n < 40) begin tick(1); n++; end
        n_checks++;
        if ({busy, ram_sel, core_nreset} !== 3'b000) begin n_errors++; $display("FAIL %s_enter_release: busy/sel/nrst=%b%b%b expected 000", name, busy, ram_sel, core_nreset); end
        n = 0;
        while (!core_nreset && n < 40) begin tick(1); n++; end
        n_checks++;
        if (n !== RELEASE_CYCLES || core_run !== 1'b1)
            begin n_errors++; $display("FAIL %s_release_len: cycles=%0d run=%b expected %0d and 1", name, n, core_run, RELEASE_CYCLES); end
    endtask

    task automatic compare_session(input string name);
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL %s_write_count: got %0d expected %0d", name, got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL %s_write%0d: got %h expected %h", name, i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if ({word_count, checksum, err} !== {exp_wc, exp_cs, exp_err})
            begin n_errors++; $display("FAIL %s_status: wc=%0d cs=%h err=%b expected wc=%0d cs=%h err=%b", name, word_count, checksum, err, exp_wc, exp_cs, exp_err); end
    endtask

    task automatic test_reset();
        int n = 0;
        nreset = 1'b0; prg = 1'b0; prg_din = 1'b0; prg_shift_clk = 1'b0; prg_latch = 1'b0;
        tick(3);
        n_checks++;
        if ({core_run, core_nreset, ram_write, ram_read, ram_sel, busy, err} !== 7'd0)
            begin n_errors++; $display("FAIL reset_ctrl: got %b expected 0000000", {core_run, core_nreset, ram_write, ram_read, ram_sel, busy, err}); end
        n_checks++;
        if ({ram_addr, ram_wdata, word_count, checksum} !== 33'd0)
            begin n_errors++; $display("FAIL reset_data: addr=%h wdata=%h wc=%0d cs=%h expected all 0", ram_addr, ram_wdata, word_count, checksum); end
        nreset = 1'b1;
        while (!core_nreset && n < 40) begin tick(1); n++; end
        n_checks++;
        if (n !== RELEASE_CYCLES) begin n_errors++; $display("FAIL reset_release_len: got %0d expected %0d", n, RELEASE_CYCLES); end
        n_checks++;
        if ({core_run, busy, ram_sel} !== 3'b100) begin n_errors++; $display("FAIL reset_run: run/busy/sel=%b%b%b expected 100", core_run, busy, ram_sel); end
    endtask

    task automatic test_single_frame();
        start_session("single");
        send_bits(32'h12A5, 16, 1'b0);
        compare_session("single");
        n_checks++;
        if (wr_long !== 0) begin n_errors++; $display("FAIL single_pulse_width: long pulses=%0d expected 0", wr_long); end
        end_session("single");
    endtask

    task automatic test_checksum_wrap();
        start_session("wrap");
        send_bits(32'h00F0, 16, 1'b0);
        send_bits(32'h0120, 16, 1'b0);
        end_session("wrap");
        compare_session("wrap_held");
        n_checks++;
        if (checksum !== 8'h10) begin n_errors++; $display("FAIL wrap_checksum: got %h expected 10", checksum); end
    endtask

    task automatic test_short_frame();
        start_session("short");
        send_bits(32'h0155, 9, 1'b0);
        compare_session("short_after_bad");
        send_bits(32'h0507, 16, 1'b0);
        compare_session("short_after_good");
        end_session("short");
    endtask

    task automatic test_collision_and_abort();
        start_session("collide");
        send_bits(32'h1234, 16, 1'b1);
        compare_session("collide");
        end_session("collide");
        start_session("abort");
        for (int i = 0; i < 5; i++) shift_bit(1'(i & 1));
        exp_err = 1'b1;
        end_session("abort");
        compare_session("abort");
    endtask

    task automatic test_random();
        for (int s = 0; s < 4; s++) begin
            start_session("rand");
            for (int f = 0; f < int'($urandom_range(5, 2)); f++) begin
                case ($urandom % 8)
                    0:       send_bits($urandom, int'($urandom_range(15, 1)), 1'b0);
                    1:       send_bits($urandom, int'($urandom_range(18, 14)), 1'b1);
                    2:       send_bits($urandom, int'($urandom_range(20, 17)), 1'b0);
                    default: send_bits($urandom, 16, 1'b0);
                endcase
            end
            compare_session("rand");
            end_session("rand");
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        start_session("b2b");
        send_bits(32'hA55A, 16, 1'b0);
        prg = 1'b0;
        while (busy && n < 40) begin tick(1); n++; end
        run_seen = 1'b0;
        prg = 1'b1;
        n = 0;
        while (!busy && n < 60) begin tick(1); n++; end
        n_checks++;
        if ({run_seen, busy, core_run} !== 3'b110) begin n_errors++; $display("FAIL b2b_reenter: run_seen/busy/run=%b%b%b expected 110", run_seen, busy, core_run); end
        end_session("b2b");
    endtask

    task automatic test_verify();
`ifdef PRG_VERIFY_EN
        start_session("vbad");
        corrupt = 1'b1; rd_cnt = 0; rd_late = 0;
        send_bits(32'h0355, 16, 1'b0);
        n_checks++;
        if ({rd_cnt, rd_late, rd_addr, err} !== {32'd1, 32'd0, 8'h03, 1'b1})
            begin n_errors++; $display("FAIL verify_bad: reads=%0d late=%0d addr=%h err=%b expected 1/0/03/1", rd_cnt, rd_late, rd_addr, err); end
        end_session("vbad");
        start_session("vgood");
        corrupt = 1'b0; rd_cnt = 0; rd_late = 0;
        send_bits(32'h0355, 16, 1'b0);
        compare_session("vgood");
        n_checks++;
        if ({rd_cnt, rd_late} !== {32'd1, 32'd0}) begin n_errors++; $display("FAIL verify_good_read: reads=%0d late=%0d expected 1/0", rd_cnt, rd_late); end
        end_session("vgood");
`else
        n_checks++;
        if (rd_cnt !== 0) begin n_errors++; $display("FAIL no_verify_read: reads=%0d expected 0", rd_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_checksum_wrap();
        test_short_frame();
        test_collision_and_abort();
        test_random();
        test_back_to_back();
        test_verify();
        n_checks++;
        if (wr_long !== 0) begin n_errors++; $display("FAIL write_pulse_width: long pulses=%0d expected 0", wr_long); end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
